// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle MIPS core.
// Takes a framed byte stream (LEN_HI, LEN_LO, N x 4 payload bytes, XOR checksum)
// and writes big-endian 32-bit words into instruction memory from word 0.
// The core stays in reset until a frame passes its length and checksum checks.
// Ports:
//   clk, reset (sync, active-low)        clock and reset
//   start                                one-cycle pulse to begin a load
//   in_valid / in_data / in_ready        byte stream handshake
//   imem_we / imem_addr / imem_wdata     registered instruction-memory write port
//   cpu_reset                            active-high core reset, low only after success
//   busy / done / err / err_code         load status
module imem_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned IdleW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCsum, StDone, StError
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          csum_q, csum_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      idle_q     <= '0;
      err_code_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      err_code_q <= err_code_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    idle_d     = idle_q;
    err_code_d = err_code_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (start && (state_q == StIdle || state_q == StDone || state_q == StError)) begin
      state_d    = StLenHi;
      err_code_d = 2'b00;
      csum_d     = '0;
      word_idx_d = '0;
      byte_cnt_d = '0;
      idle_d     = '0;
    end else if (busy) begin
      // Timeout takes priority over a byte arriving on the same cycle.
      if (idle_q == IdleW'(TIMEOUT_CYC)) begin
        state_d    = StError;
        err_code_d = 2'b11;
      end else if (accept) begin
        idle_d = '0;
        case (state_q)
          StLenHi: begin
            len_hi_d = in_data;
            state_d  = StLenLo;
          end
          StLenLo: begin
            len_d = {len_hi_q, in_data};
            if ({1'b0, len_hi_q, in_data} > MaxWords) begin
              state_d    = StError;
              err_code_d = 2'b01;
            end else if ({len_hi_q, in_data} == 16'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
          StData: begin
            csum_d = csum_q ^ in_data;
            if (byte_cnt_q == 2'd3) begin
              we_d       = 1'b1;
              addr_d     = word_idx_q;
              wdata_d    = {asm_q, in_data};
              word_idx_d = word_idx_q + 1'b1;
              byte_cnt_d = 2'd0;
              if (16'(word_idx_q) == len_q - 16'd1) state_d = StCsum;
            end else begin
              asm_d      = {asm_q[15:0], in_data};
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
          StCsum: begin
            if (in_data == csum_q) begin
              state_d = StDone;
            end else begin
              state_d    = StError;
              err_code_d = 2'b10;
            end
          end
          default: ;
        endcase
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_reset = 1'b1;
    case (state_q)
      StLenHi, StLenLo, StData, StCsum: begin
        busy     = 1'b1;
        in_ready = 1'b1;
      end
      StDone: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      StError: err = 1'b1;
      default: ;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TO     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled away from the active edge
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                wr_cyc[$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 4) begin
      @(posedge clk);
      #1 waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready wait: got %b, expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [127:0] bytes;  // first byte in the top 8 bits
    logic        exp_done;
    logic [1:0]  exp_code;
    int          exp_writes;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vecs[5];

  logic [31:0] prog[10];
  logic [7:0]  csum;
  logic [127:0] sh;

  initial begin
    vecs[0] = '{"single", 7,  {56'h0001_2009_0005_2C, 72'd0}, 1'b1, 2'b00, 1, 32'h20090005};
    vecs[1] = '{"badcsum", 7, {56'h0001_2009_0005_2D, 72'd0}, 1'b0, 2'b10, 1, 32'h20090005};
    vecs[2] = '{"toolong", 2, {16'h0101, 112'd0},             1'b0, 2'b01, 0, 32'h0};
    vecs[3] = '{"zerolen", 3, {24'h000000, 104'd0},           1'b1, 2'b00, 0, 32'h0};
    vecs[4] = '{"twoword", 11, {88'h0002_1234_5678_9ABC_DEF1_01, 40'd0},
                1'b1, 2'b00, 2, 32'h12345678};
    prog = '{32'h20090005, 32'h200A000A, 32'h012A4020, 32'h012A4022, 32'h012A4024,
             32'h012A4025, 32'hAC0A0000, 32'h8C0B0000, 32'h11690002, 32'h08000000};

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst imem_we", {31'd0, imem_we}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst err_code", {30'd0, err_code}, 32'd0);
    check("rst addr", {24'd0, imem_addr}, 32'd0);
    check("rst wdata", imem_wdata, 32'd0);

    // Single word, hand-checked write latency
    @(posedge clk);
    #1 clear_log();
    pulse_start();
    @(negedge clk);
    check("start busy", {31'd0, busy}, 32'd1);
    check("start in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h20);
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h05);
    @(negedge clk);
    check("lat we", {31'd0, imem_we}, 32'd1);
    check("lat addr", {24'd0, imem_addr}, 32'd0);
    check("lat wdata", imem_wdata, 32'h20090005);
    @(negedge clk);
    check("lat we low", {31'd0, imem_we}, 32'd0);
    check("hold wdata", imem_wdata, 32'h20090005);
    check("pre-csum cpu_reset", {31'd0, cpu_reset}, 32'd1);
    send_byte(8'h2C);
    @(negedge clk);
    check("single done", {31'd0, done}, 32'd1);
    check("single cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("single busy", {31'd0, busy}, 32'd0);
    check("done in_ready", {31'd0, in_ready}, 32'd0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      #1 clear_log();
      pulse_start();
      @(negedge clk);
      check({vecs[v].name, " clr done"}, {31'd0, done}, 32'd0);
      check({vecs[v].name, " clr err"}, {31'd0, err}, 32'd0);
      check({vecs[v].name, " clr code"}, {30'd0, err_code}, 32'd0);
      sh = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(sh[127:120]);
        sh = sh << 8;
      end
      @(negedge clk);
      check({vecs[v].name, " done"}, {31'd0, done}, {31'd0, vecs[v].exp_done});
      check({vecs[v].name, " err"}, {31'd0, err}, {31'd0, ~vecs[v].exp_done});
      check({vecs[v].name, " code"}, {30'd0, err_code}, {30'd0, vecs[v].exp_code});
      check({vecs[v].name, " cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~vecs[v].exp_done});
      check({vecs[v].name, " busy"}, {31'd0, busy}, 32'd0);
      check({vecs[v].name, " writes"}, wr_addr.size(), vecs[v].exp_writes);
      if (vecs[v].exp_writes > 0 && wr_addr.size() > 0) begin
        check({vecs[v].name, " w0 addr"}, {24'd0, wr_addr[0]}, 32'd0);
        check({vecs[v].name, " w0 data"}, wr_data[0], vecs[v].exp_w0);
      end
    end

    // Ten-word program, back-to-back
    @(posedge clk);
    #1 clear_log();
    pulse_start();
    csum = 8'h00;
    send_byte(8'h00); send_byte(8'h0A);
    for (int w = 0; w < 10; w++) begin
      for (int b = 3; b >= 0; b--) begin
        csum = csum ^ prog[w][8*b +: 8];
        send_byte(prog[w][8*b +: 8]);
      end
    end
    send_byte(csum);
    @(negedge clk);
    check("prog done", {31'd0, done}, 32'd1);
    check("prog cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("prog writes", wr_addr.size(), 10);
    if (wr_addr.size() == 10) begin
      for (int w = 0; w < 10; w++) begin
        check($sformatf("prog addr %0d", w), {24'd0, wr_addr[w]}, w);
        check($sformatf("prog data %0d", w), wr_data[w], prog[w]);
        if (w > 0) check($sformatf("prog gap %0d", w), wr_cyc[w] - wr_cyc[w-1], 4);
      end
    end

    // Full-depth frame: 256 words accepted, last address 255
    @(posedge clk);
    #1 clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    for (int w = 0; w < 256; w++) begin
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'(w));
    end
    send_byte(8'h00);  // A5 cancels over 256 words, XOR of 0..255 is 0
    @(negedge clk);
    check("full done", {31'd0, done}, 32'd1);
    check("full writes", wr_addr.size(), 256);
    if (wr_addr.size() == 256) begin
      check("full last addr", {24'd0, wr_addr[255]}, 32'd255);
      check("full last data", wr_data[255], 32'hA50000FF);
    end

    // Timeout: three bytes then stall
    @(posedge clk);
    #1 clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h20);
    repeat (TO + 1) @(negedge clk);
    check("to early err", {31'd0, err}, 32'd0);
    check("to early busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("to err", {31'd0, err}, 32'd1);
    check("to code", {30'd0, err_code}, 32'd3);
    check("to cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("to writes", wr_addr.size(), 0);

    // Reset mid-DATA, with start asserted on the same edge
    @(posedge clk);
    #1 clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst addr", {24'd0, imem_addr}, 32'd0);
    check("midrst wdata", imem_wdata, 32'd0);
    check("midrst writes", wr_addr.size(), 1);

    // Start mid-frame is ignored, including one coinciding with a byte
    @(posedge clk);
    #1 clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h20);
    start = 1'b1;
    send_byte(8'h09);
    start = 1'b0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h2C);
    @(negedge clk);
    check("midstart done", {31'd0, done}, 32'd1);
    check("midstart writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("midstart data", wr_data[0], 32'h20090005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the MIPS single-cycle core. Receives a framed byte stream over a valid/ready interface and writes 32-bit instruction words into instruction memory, starting at word 0. Holds the core in reset for the whole load and releases it only after a frame passes its length and checksum checks. It is the hardware writer side of instruction memory; the core's fetch port is the reader.

## Interface
- ADDR_W, 8: instruction-memory word-address width; depth is 2^ADDR_W words (256).
- TIMEOUT_CYC, 1024: idle cycles allowed between accepted bytes before a timeout error; minimum 2.
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low.
- start  input  1  one-cycle pulse that begins a new load.
- in_valid  input  1  a byte is presented on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address being written.
- imem_wdata  output  32  instruction word being written.
- cpu_reset  output  1  active-high reset to the core.
- busy  output  1  a load is in progress.
- done  output  1  sticky; the last load succeeded.
- err  output  1  sticky; the last load failed.
- err_code  output  2  01 = length too large, 10 = checksum mismatch, 11 = timeout, 00 = none.

## Operation
- Frame format, byte order as sent:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 payload bytes, each word big-endian (MSB first).
  - One checksum byte, equal to the XOR of all payload bytes only; the length bytes are excluded.
- States:
  - IDLE: entered on reset.
  - LEN_HI, LEN_LO, DATA, CSUM: the receive states.
  - DONE, ERROR: terminal until the next start.
- Transitions:
  - start in IDLE, DONE or ERROR goes to LEN_HI, clears done, err, err_code, the checksum accumulator, the word index and the byte counter.
  - start in any receive state is ignored.
  - LEN_LO goes to ERROR/01 if N > 2^ADDR_W, to CSUM if N = 0, otherwise to DATA.
  - DATA shifts bytes into a 32-bit assembly register. On the 4th byte it issues the write; after word N-1 it goes to CSUM.
  - CSUM goes to DONE if the received byte equals the accumulator, otherwise to ERROR/10.
  - Any receive state goes to ERROR/11 when the idle counter reaches TIMEOUT_CYC.
- Handshake:
  - A byte transfers on a cycle with in_valid & in_ready.
  - in_ready = 1 in every receive state, 0 in IDLE, DONE and ERROR.
  - in_ready does not depend combinationally on in_valid.
- Write port:
  - imem_we, imem_addr and imem_wdata are registered.
  - imem_addr = word index, 0 to N-1, with no wrap: the length check guarantees the index fits in ADDR_W.
  - imem_addr and imem_wdata hold their last values when imem_we = 0.
- Core reset:
  - cpu_reset = 1 in IDLE, the receive states and ERROR. It is 0 only in DONE.
  - A failed load never releases the core.
- Status:
  - busy = 1 exactly in the receive states.
  - done = 1 exactly in DONE, err = 1 exactly in ERROR.
- Idle counter: clears on every accepted byte and on entry to LEN_HI, and increments on every other receive-state cycle.

## Timing
- Reset (reset = 0 at a clock edge), values after that edge:
  - state IDLE, cpu_reset = 1.
  - in_ready, imem_we, busy, done, err = 0.
  - err_code = 00, imem_addr = 0, imem_wdata = 0.
  - Reset wins over start and any handshake on the same edge.
- start accepted at edge T: busy = 1 and in_ready = 1 from T+1.
- Write latency: the 4th byte of word k accepted at edge T gives imem_we = 1 with addr k and the full word for exactly the cycle after T.
- Back-to-back words: one byte per cycle is sustained with no stall. The write of word k overlaps the reception of word k+1.
- Checksum byte accepted at edge T: the state is DONE or ERROR from T+1, and cpu_reset falls at T+1 on success.
- Timeout: with no byte accepted, ERROR is entered TIMEOUT_CYC cycles after the last accept, or after entry to LEN_HI. The error is observable one edge later.
- Reset mid-frame: the frame is abandoned, and writes already issued stay in memory.

## Test plan
- Single word: start; bytes 00 01 20 09 00 05 2C. Expect one imem_we with addr 0 and data 0x20090005, then DONE, done = 1, cpu_reset = 0.
- Ten-word program (0x20090005, 0x200A000A, 0x012A4020, 0x012A4022, 0x012A4024, 0x012A4025, 0xAC0A0000, 0x8C0B0000, 0x11690002, 0x08000000) sent back-to-back with the correct XOR checksum. Expect ten consecutive-per-4-cycle writes at addr 0–9 and done = 1; the core then runs it (afterwards $t1 = 5, $t2 = 10).
- Bad checksum: the single-word frame with checksum 2D. Expect the write to addr 0 to occur, then err = 1, err_code = 10, cpu_reset held at 1.
- Length 0x0101 with ADDR_W = 8. Expect ERROR/01 after LEN_LO, with no imem_we ever. Length 0x0000 with checksum 00 gives DONE.
- Timeout with TIMEOUT_CYC = 16: send 00 01 20, then stall in_valid. Expect err_code = 11 after 16 idle cycles and no write.
- reset = 0 mid-DATA, and a start pulse mid-frame. Reset returns to IDLE with cpu_reset = 1 and busy = 0. The mid-frame start is ignored and the frame completes normally.
